// File: rtl/agu_pkg.sv
// Shared types for the AGU reservation queue.
//   XLEN        operand/address width used by the entry record
//   TAG_W       ROB/CDB tag width used by the entry record
//   agu_entry_t one queue entry: operands with tags/valids, rd tag, funct3, ls, imm, entry valid
//   cdb_wake    applies a CDB broadcast to an entry's missing operands
package agu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 6;

   typedef struct packed {
      logic [XLEN-1:0]  op1_data;
      logic [TAG_W-1:0] op1_tag;
      logic             op1_valid;
      logic [XLEN-1:0]  op2_data;
      logic [TAG_W-1:0] op2_tag;
      logic             op2_valid;
      logic [TAG_W-1:0] rd_tag;
      logic [2:0]       funct3;
      logic             ls;
      logic [XLEN-1:0]  imm;
      logic             valid;
   } agu_entry_t;

   // Captures CDB data into any still-missing operand whose tag matches.
   function automatic agu_entry_t cdb_wake(input agu_entry_t e, input logic v,
                                           input logic [TAG_W-1:0] tag,
                                           input logic [XLEN-1:0] data);
      agu_entry_t r;
      r = e;
      if (v && e.valid) begin
         if (!e.op1_valid && (e.op1_tag == tag)) begin
            r.op1_data  = data;
            r.op1_valid = 1'b1;
         end
         if (!e.op2_valid && (e.op2_tag == tag)) begin
            r.op2_data  = data;
            r.op2_valid = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/agu_issue_queue_param_if.sv
// Dispatch/issue bundle of the AGU reservation queue.
//   master: dispatch source and LSU side (drives disp_*, ex_ready)
//   slave : the queue (drives queue_full, count, issue_valid, ex_*)
interface agu_issue_queue_param_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 6
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             disp_en;
   logic [XLEN-1:0]  disp_op1_data;
   logic [TAG_W-1:0] disp_op1_tag;
   logic             disp_op1_valid;
   logic [XLEN-1:0]  disp_op2_data;
   logic [TAG_W-1:0] disp_op2_tag;
   logic             disp_op2_valid;
   logic [TAG_W-1:0] disp_rd_tag;
   logic [2:0]       disp_funct3;
   logic             disp_ls;
   logic [XLEN-1:0]  disp_imm;
   logic             queue_full;
   logic [CNT_W-1:0] count;
   logic             ex_ready;
   logic             issue_valid;
   logic [XLEN-1:0]  ex_address;
   logic [XLEN-1:0]  ex_data;
   logic [TAG_W-1:0] ex_rd_tag;
   logic [2:0]       ex_funct3;
   logic             ex_ls;

   modport master (
      output disp_en, disp_op1_data, disp_op1_tag, disp_op1_valid,
             disp_op2_data, disp_op2_tag, disp_op2_valid,
             disp_rd_tag, disp_funct3, disp_ls, disp_imm, ex_ready,
      input  queue_full, count, issue_valid, ex_address, ex_data,
             ex_rd_tag, ex_funct3, ex_ls
   );

   modport slave (
      input  disp_en, disp_op1_data, disp_op1_tag, disp_op1_valid,
             disp_op2_data, disp_op2_tag, disp_op2_valid,
             disp_rd_tag, disp_funct3, disp_ls, disp_imm, ex_ready,
      output queue_full, count, issue_valid, ex_address, ex_data,
             ex_rd_tag, ex_funct3, ex_ls
   );

endinterface

// File: rtl/agu_iq_entry.sv
// One AGU queue slot.
//   clk, rst       clock, asynchronous active-low reset
//   flush          clear slot
//   write, disp    load the dispatching entry (has priority over shift)
//   shift, upper   take the entry from the slot above (collapse)
//   cdb_*          wakeup broadcast, applied to whatever is loaded or held
//   q, ready       stored entry and its issue eligibility
module agu_iq_entry
   import agu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             write,
   input  logic             shift,
   input  agu_entry_t       disp,
   input  agu_entry_t       upper,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output agu_entry_t       q,
   output logic             ready
);

   agu_entry_t src;
   agu_entry_t nxt;

   always_comb begin
      src = q;
      if (write) begin
         src = disp;
      end else if (shift) begin
         src = upper;
      end
      nxt = cdb_wake(src, cdb_valid, cdb_tag, cdb_data);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else begin
         q <= nxt;
      end
   end

   // Loads never wait on op2.
   assign ready = q.valid & q.op1_valid & (~q.ls | q.op2_valid);

endmodule

// File: rtl/agu_issue_queue_param.sv
// Parametrised AGU reservation queue (collapsing, entry 0 oldest).
//   clk, rst   clock, asynchronous active-low reset
//   flush      discard all entries
//   cdb_*      CDB broadcast for operand wakeup
//   io         dispatch in, occupancy out, issue bundle with valid/ready
// XLEN/TAG_W must equal the agu_pkg widths used by the entry record.
module agu_issue_queue_param #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned XLEN     = agu_pkg::XLEN,
   parameter int unsigned TAG_W    = agu_pkg::TAG_W,
   parameter int unsigned IN_ORDER = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   agu_issue_queue_param_if.slave io
);
   import agu_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] wslot;
   logic             full;
   logic             fire;
   logic             accept;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] sel_write;
   logic [DEPTH-1:0] sel_shift;
   agu_entry_t       q     [DEPTH];
   agu_entry_t       upper [DEPTH];
   agu_entry_t       disp;
   agu_entry_t       sel;

   assign full   = (cnt_q == CNT_W'(DEPTH));
   assign fire   = pick_valid & io.ex_ready;
   // A full queue still accepts when an issue frees a slot the same cycle.
   assign accept = io.disp_en & (~full | fire);
   assign wslot  = fire ? (cnt_q - CNT_W'(1)) : cnt_q;

   always_comb begin
      disp           = '0;
      disp.op1_data  = io.disp_op1_data;
      disp.op1_tag   = io.disp_op1_tag;
      disp.op1_valid = io.disp_op1_valid;
      disp.op2_data  = io.disp_op2_data;
      disp.op2_tag   = io.disp_op2_tag;
      disp.op2_valid = io.disp_op2_valid;
      disp.rd_tag    = io.disp_rd_tag;
      disp.funct3    = io.disp_funct3;
      disp.ls        = io.disp_ls;
      disp.imm       = io.disp_imm;
      disp.valid     = 1'b1;
   end

   // Descending scan so the lowest ready index wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      if (IN_ORDER != 0) begin
         pick_valid = rdy[0];
      end else begin
         for (int unsigned i = DEPTH; i > 0; i--) begin
            if (rdy[i-1]) begin
               pick_valid = 1'b1;
               pick_idx   = IDX_W'(i - 1);
            end
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      if (i == DEPTH - 1) begin : g_top
         assign upper[i] = '0;
      end else begin : g_mid
         assign upper[i] = q[i+1];
      end

      assign sel_shift[i] = fire & (IDX_W'(i) >= pick_idx);
      assign sel_write[i] = accept & (CNT_W'(i) == wslot);

      agu_iq_entry u_entry (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .write     (sel_write[i]),
         .shift     (sel_shift[i]),
         .disp      (disp),
         .upper     (upper[i]),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .q         (q[i]),
         .ready     (rdy[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(fire);
      end
   end

   assign sel = q[pick_idx];

   always_comb begin
      io.ex_address = '0;
      io.ex_data    = '0;
      io.ex_rd_tag  = '0;
      io.ex_funct3  = '0;
      io.ex_ls      = 1'b0;
      if (pick_valid) begin
         io.ex_address = sel.op1_data + sel.imm;
         io.ex_data    = sel.op2_data;
         io.ex_rd_tag  = sel.rd_tag;
         io.ex_funct3  = sel.funct3;
         io.ex_ls      = sel.ls;
      end
   end

   assign io.issue_valid = pick_valid;
   assign io.queue_full  = full;
   assign io.count       = cnt_q;

endmodule

// File: tb/tb_agu_issue_queue_param.sv
// Directed bench for agu_issue_queue_param: an in-order and an oldest-ready
// instance share one stimulus stream; expected issue bundles are queued at
// dispatch and compared when each instance issues.
module tb_agu_issue_queue_param;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [5:0]  rd;
      logic [2:0]  f3;
      logic        ls;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        cdb_valid = 1'b0;
   logic [5:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;

   logic        disp_en = 1'b0;
   logic [31:0] op1_d = '0, op2_d = '0, imm = '0;
   logic [5:0]  op1_t = '0, op2_t = '0, rd_t = '0;
   logic        op1_v = 1'b0, op2_v = 1'b0, ls = 1'b0, ex_ready = 1'b0;
   logic [2:0]  f3 = '0;

   int errors = 0;
   int checks = 0;

   bundle_t sb0[$];
   bundle_t sb1[$];

   logic       iv   [2];
   logic       full [2];
   logic [2:0] cnt  [2];
   bundle_t    out  [2];

   always #5 clk = ~clk;

   agu_issue_queue_param_if #(.DEPTH(4), .XLEN(32), .TAG_W(6)) io0 ();
   agu_issue_queue_param_if #(.DEPTH(4), .XLEN(32), .TAG_W(6)) io1 ();

   agu_issue_queue_param #(.DEPTH(4), .XLEN(32), .TAG_W(6), .IN_ORDER(1)) dut_io (
      .clk(clk), .rst(rst), .flush(flush), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .io(io0));

   agu_issue_queue_param #(.DEPTH(4), .XLEN(32), .TAG_W(6), .IN_ORDER(0)) dut_oo (
      .clk(clk), .rst(rst), .flush(flush), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .io(io1));

   assign io0.disp_en = disp_en;         assign io1.disp_en = disp_en;
   assign io0.disp_op1_data = op1_d;     assign io1.disp_op1_data = op1_d;
   assign io0.disp_op1_tag = op1_t;      assign io1.disp_op1_tag = op1_t;
   assign io0.disp_op1_valid = op1_v;    assign io1.disp_op1_valid = op1_v;
   assign io0.disp_op2_data = op2_d;     assign io1.disp_op2_data = op2_d;
   assign io0.disp_op2_tag = op2_t;      assign io1.disp_op2_tag = op2_t;
   assign io0.disp_op2_valid = op2_v;    assign io1.disp_op2_valid = op2_v;
   assign io0.disp_rd_tag = rd_t;        assign io1.disp_rd_tag = rd_t;
   assign io0.disp_funct3 = f3;          assign io1.disp_funct3 = f3;
   assign io0.disp_ls = ls;              assign io1.disp_ls = ls;
   assign io0.disp_imm = imm;            assign io1.disp_imm = imm;
   assign io0.ex_ready = ex_ready;       assign io1.ex_ready = ex_ready;

   assign iv[0] = io0.issue_valid;       assign iv[1] = io1.issue_valid;
   assign full[0] = io0.queue_full;      assign full[1] = io1.queue_full;
   assign cnt[0] = io0.count;            assign cnt[1] = io1.count;
   assign out[0] = {io0.ex_address, io0.ex_data, io0.ex_rd_tag, io0.ex_funct3, io0.ex_ls};
   assign out[1] = {io1.ex_address, io1.ex_data, io1.ex_rd_tag, io1.ex_funct3, io1.ex_ls};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input int d, input int n);
      check({tag, "_count"}, 128'(cnt[d]), 128'(n));
      check({tag, "_iv"}, 128'(iv[d]), 128'(0));
      check({tag, "_full"}, 128'(full[d]), 128'(n == 4));
   endtask

   // Compares instance d's bundle with scoreboard entry idx; removes it when pop is set.
   task automatic check_bundle(input string tag, input int d, input int idx, input bit pop);
      bundle_t exp;
      int sz;
      sz = (d == 0) ? sb0.size() : sb1.size();
      if (sz <= idx) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=empty scoreboard expected=entry %0d", tag, idx);
         return;
      end
      exp = (d == 0) ? sb0[idx] : sb1[idx];
      check({tag, "_iv"}, 128'(iv[d]), 128'(1));
      check(tag, 128'(out[d]), 128'(exp));
      if (pop) begin
         if (d == 0) sb0.delete(idx);
         else        sb1.delete(idx);
      end
   endtask

   task automatic drive(input logic [31:0] a1, input logic [5:0] t1, input logic v1,
                        input logic [31:0] a2, input logic [5:0] t2, input logic v2,
                        input logic [5:0] rd, input logic [2:0] fn, input logic l,
                        input logic [31:0] im);
      disp_en = 1'b1;
      op1_d = a1; op1_t = t1; op1_v = v1;
      op2_d = a2; op2_t = t2; op2_v = v2;
      rd_t = rd; f3 = fn; ls = l; imm = im;
   endtask

   task automatic push(input bundle_t b);
      sb0.push_back(b);
      sb1.push_back(b);
   endtask

   initial begin
      // Reset state
      tick();
      for (int d = 0; d < 2; d++) begin
         check_idle("reset", d, 0);
         check("reset_bundle", 128'(out[d]), 128'(0));
      end
      rst = 1'b1;
      tick();

      // Load ready at dispatch
      ex_ready = 1'b1;
      drive(32'h1000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 6'd1, 3'd2, 1'b0, 32'h10);
      push('{32'h1010, 32'h0, 6'd1, 3'd2, 1'b0});
      tick();
      disp_en = 1'b0;
      for (int d = 0; d < 2; d++) check_bundle("load_issue", d, 0, 1'b1);
      tick();
      for (int d = 0; d < 2; d++) check_idle("load_drain", d, 0);

      // Store waiting on CDB tag 5
      drive(32'h0, 6'd5, 1'b0, 32'hDEAD, 6'd0, 1'b1, 6'd2, 3'd2, 1'b1, 32'h24);
      push('{32'h2024, 32'hDEAD, 6'd2, 3'd2, 1'b1});
      tick();
      disp_en = 1'b0;
      check_idle("wait1", 0, 1);
      tick();
      check_idle("wait2", 1, 1);
      cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h2000;
      tick();
      cdb_valid = 1'b0;
      for (int d = 0; d < 2; d++) check_bundle("cdb_wake", d, 0, 1'b1);
      tick();
      for (int d = 0; d < 2; d++) check_idle("wake_drain", d, 0);

      // Same-cycle CDB capture on dispatch
      drive(32'h0, 6'd7, 1'b0, 32'h55, 6'd0, 1'b1, 6'd3, 3'd0, 1'b0, 32'h4);
      cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hAA;
      push('{32'hAE, 32'h55, 6'd3, 3'd0, 1'b0});
      tick();
      disp_en = 1'b0; cdb_valid = 1'b0;
      for (int d = 0; d < 2; d++) check_bundle("bypass", d, 0, 1'b1);
      tick();
      for (int d = 0; d < 2; d++) check_idle("bypass_drain", d, 0);

      // Fill with back-pressure, overflow dispatch, then issue+dispatch at full
      ex_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(32'h100 * (k + 1), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1, 6'(10 + k), 3'd1, 1'b0, 32'(k));
         push('{32'h100 * (k + 1) + 32'(k), 32'(k), 6'(10 + k), 3'd1, 1'b0});
         tick();
      end
      drive(32'h9000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 6'd14, 3'd1, 1'b0, 32'h0);
      for (int d = 0; d < 2; d++) begin
         check("full_flag", 128'(full[d]), 128'(1));
         check("full_count", 128'(cnt[d]), 128'(4));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         check("ovf_count", 128'(cnt[d]), 128'(4));
         check_bundle("ovf_head", d, 0, 1'b0);
      end
      drive(32'h7000, 6'd0, 1'b1, 32'h77, 6'd0, 1'b1, 6'd15, 3'd4, 1'b0, 32'h8);
      push('{32'h7008, 32'h77, 6'd15, 3'd4, 1'b0});
      ex_ready = 1'b1;
      for (int d = 0; d < 2; d++) check_bundle("full_issue", d, 0, 1'b1);
      tick();
      disp_en = 1'b0;
      for (int d = 0; d < 2; d++) check("swap_count", 128'(cnt[d]), 128'(4));
      for (int k = 0; k < 4; k++) begin
         for (int d = 0; d < 2; d++) check_bundle("drain", d, 0, 1'b1);
         tick();
      end
      for (int d = 0; d < 2; d++) check_idle("drain_done", d, 0);

      // Issue mode: entry0 waiting on tag 9, entry1 ready
      ex_ready = 1'b0;
      drive(32'h0, 6'd9, 1'b0, 32'h11, 6'd0, 1'b1, 6'd20, 3'd2, 1'b0, 32'h8);
      push('{32'h3008, 32'h11, 6'd20, 3'd2, 1'b0});
      tick();
      drive(32'h4000, 6'd0, 1'b1, 32'h22, 6'd0, 1'b1, 6'd21, 3'd2, 1'b0, 32'h4);
      push('{32'h4004, 32'h22, 6'd21, 3'd2, 1'b0});
      tick();
      disp_en = 1'b0;
      check("mode_inorder_blocked", 128'(iv[0]), 128'(0));
      check_bundle("mode_oldest_ready", 1, 1, 1'b1);
      ex_ready = 1'b1;
      tick();
      check("mode_inorder_count", 128'(cnt[0]), 128'(2));
      check_idle("mode_ooo_left", 1, 1);
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h3000;
      tick();
      cdb_valid = 1'b0;
      for (int d = 0; d < 2; d++) check_bundle("mode_entry0", d, 0, 1'b1);
      tick();
      check_bundle("mode_inorder_second", 0, 0, 1'b1);
      check_idle("mode_ooo_done", 1, 0);
      tick();
      check_idle("mode_inorder_done", 0, 0);

      // Flush
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(32'h500, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 6'(30 + k), 3'd0, 1'b0, 32'(k));
         tick();
      end
      disp_en = 1'b0;
      for (int d = 0; d < 2; d++) check("pre_flush_count", 128'(cnt[d]), 128'(3));
      flush = 1'b1;
      ex_ready = 1'b1;
      drive(32'h600, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 6'd40, 3'd0, 1'b0, 32'h0);
      tick();
      flush = 1'b0; disp_en = 1'b0; ex_ready = 1'b0;
      for (int d = 0; d < 2; d++) check_idle("flush", d, 0);

      // Asynchronous reset mid-operation
      for (int k = 0; k < 2; k++) begin
         drive(32'h800, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 6'(50 + k), 3'd3, 1'b1, 32'h1);
         tick();
      end
      disp_en = 1'b0;
      check("pre_rst_count", 128'(cnt[0]), 128'(2));
      check("pre_rst_iv", 128'(iv[0]), 128'(1));
      #2;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_idle("async_rst", d, 0);
         check("async_rst_bundle", 128'(out[d]), 128'(0));
      end
      sb0.delete();
      sb1.delete();
      tick();
      rst = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
